pipelined_instruction_decoder: RTL and testbench
================================================

Name: pipelined_instruction_decoder

Overview:
- Registered successor to the single-cycle instruction decoder. It sits between instruction fetch and operand read in the pipelined datapath.
- Decodes the 32-bit IR into the standard control word and adds:
  - a valid/ready handshake on both sides;
  - sign- or zero-extended immediate generation;
  - an illegal-opcode flag;
  - a parametrised-depth RAW hazard scoreboard that inserts bubbles;
  - a synchronous flush.

Parameters:
- DATA_W, 32, width of the extended immediate output (must be at least IMM_W).
- IMM_W, 15, immediate field width, taken from IR[IMM_W-1:0].
- HAZ_DEPTH, 2, number of in-flight destination entries checked for RAW hazards (1..8).

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-high reset.
- flush  in  1  synchronous; discards the output register and clears the scoreboard.
- in_valid  in  1  IR_instruction holds a valid instruction.
- in_ready  out  1  combinational; the instruction is accepted on in_valid && in_ready.
- IR_instruction  in  32  opcode[31:25], DR[24:20], SA[19:15], SB[14:10], imm[IMM_W-1:0].
- out_valid  out  1  the registered control word is valid.
- out_ready  in  1  downstream accepts the word on out_valid && out_ready.
- RW, MW, PS, MA, MB, CS  out  1 each  registered control bits.
- MD, BS  out  2 each  registered control fields.
- FS  out  5  registered function select.
- DA, AA, BA  out  5 each  registered register addresses.
- imm_ext  out  DATA_W  registered immediate: sign-extended when CS=1, zero-extended when CS=0.
- illegal  out  1  registered; the opcode is not in PATT.INC.

Behaviour:
- Opcode encodings are taken from PATT.INC. Every control field not listed below is 0.
- For all opcodes except NOP: AA=SA, BA=SB, DA=DR. For NOP: AA=BA=DA=0.
- Control word by opcode group:
  - ADD/SUB/AND/OR/XOR: RW=1, MD=00, MB=0. FS is 00010/00101/01000/01010/01100 respectively.
  - SLT: as SUB, but MD=10.
  - ADI/SBI: RW=1, MB=1, CS=1. FS is 00010/00101.
  - ANI/ORI/XRI/AIU/SIU: RW=1, MB=1, CS=0. FS is 01000/01010/01100/00010/00101.
  - MOV/NOT/LSL/LSR: RW=1. FS is 00000/01110/10000/10001.
  - ST: MW=1.
  - LOD: RW=1, MD=01.
  - JMR: BS=10.
  - BZ: BS=01, PS=0, MB=1, CS=1.
  - BNZ: BS=01, PS=1, MB=1, CS=1.
  - JMP: BS=11, MB=1, CS=1.
  - JML: BS=11, RW=1, FS=00111, MB=1, MA=1, CS=1.
- Unknown opcode: decoded as NOP with illegal=1. It is still delivered with out_valid=1 so control can trap.
- Source usage for hazard checking:
  - useA applies to every opcode except NOP, JMP and JML.
  - useB applies to ADD, SUB, SLT, AND, OR, XOR and ST.
  - Register 0 never causes a hazard.
- Load condition: load = !out_valid || out_ready.
- Scoreboard: hist[0..HAZ_DEPTH-1] holds 5-bit destinations; hist[0] is the newest.
- hazard = in_valid && ((useA && SA!=0 && SA matches any hist entry) || (useB && SB!=0 && SB matches any hist entry)).
- in_ready = load && !hazard && !flush && !RESET.
- Every cycle with load=1 (and no flush):
  - hist shifts by one.
  - hist[0] receives DR when the instruction is accepted with RW=1 and DR!=0; otherwise it receives 0 (bubble).
  - The output register loads the decoded word with out_valid=in_valid&&in_ready, i.e. a bubble when there is a hazard or no input.
- load=0 (downstream stall): all registers hold and in_ready=0.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one instruction per cycle when there are no hazards and no stalls.
- flush, which has priority over load:
  - next cycle out_valid=0 and all hist entries are 0;
  - the input is not accepted that cycle.
- RESET, which has priority over flush:
  - all outputs 0, out_valid=0, hist cleared;
  - in_ready=0 while RESET is high;
  - a reset arriving mid-stall drops the held word.
- Control outputs hold their last value while out_valid=0. Consumers must qualify them with out_valid.
- A hazard resolves after HAZ_DEPTH load cycles, because bubbles age the scoreboard.

Test Plan:
- Reset: RESET=1 for 2 cycles, then in_valid=1 with ADD IR=0x04308800 (DR=3, SA=1, SB=2) -> all outputs 0 during reset; the cycle after acceptance out_valid=1, RW=1, FS=00010, MB=0, DA=3, AA=1, BA=2.
- Sign extension: ADI with imm=0x7FFF -> CS=1, imm_ext=0xFFFFFFFF. ANI with imm=0x7FFF -> CS=0, imm_ext=0x00007FFF.
- RAW hazard with HAZ_DEPTH=2: ADD R3 then SUB R4=R3-R1 back-to-back, out_ready=1 -> SUB held for 2 cycles (in_ready=0, two bubbles) and delivered on the 3rd cycle. Repeating with DR=0 in the ADD -> no stall.
- Backpressure: out_ready=0 for 3 cycles during a stream of MOVs -> out_valid stays 1, the word and DA are stable, in_ready=0; no instruction is lost or duplicated once out_ready=1.
- Flush and illegal opcode: flush asserted while a JMP is in the output register and a hazard is pending -> next cycle out_valid=0, the hazard is cleared, and the next instruction is accepted. Opcode 0x7F -> out_valid=1, illegal=1, RW=0, MW=0, BS=00.

Source files
------------

// File: rtl/pipelined_instruction_decoder_if.sv
// Bundle between fetch and operand read: instruction in, registered control word out.
// valid/ready: a transfer happens on a rising CLK edge where valid && ready; the sender holds its payload stable until then.
interface pipelined_instruction_decoder_if #(
    parameter int DATA_W = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       IR_instruction;
    logic              out_valid;
    logic              out_ready;
    logic              RW;
    logic              MW;
    logic              PS;
    logic              MA;
    logic              MB;
    logic              CS;
    logic [1:0]        MD;
    logic [1:0]        BS;
    logic [4:0]        FS;
    logic [4:0]        DA;
    logic [4:0]        AA;
    logic [4:0]        BA;
    logic [DATA_W-1:0] imm_ext;
    logic              illegal;

    modport master (
        output flush, in_valid, IR_instruction, out_ready,
        input  in_ready, out_valid, RW, MW, PS, MA, MB, CS, MD, BS, FS,
        input  DA, AA, BA, imm_ext, illegal
    );

    modport slave (
        input  flush, in_valid, IR_instruction, out_ready,
        output in_ready, out_valid, RW, MW, PS, MA, MB, CS, MD, BS, FS,
        output DA, AA, BA, imm_ext, illegal
    );
endinterface

// File: rtl/pipelined_instruction_decoder.sv
// Registered instruction decoder with immediate extension, illegal-opcode flag,
// RAW hazard scoreboard (bubble insertion) and synchronous flush.
module pipelined_instruction_decoder #(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 15,
    parameter int HAZ_DEPTH = 2
) (
    input logic                          CLK,
    input logic                          RESET,
    pipelined_instruction_decoder_if.slave bus
);
    localparam logic [6:0] OP_NOP = 7'h00, OP_ST  = 7'h01, OP_ADD = 7'h02, OP_SUB = 7'h05;
    localparam logic [6:0] OP_JML = 7'h07, OP_AND = 7'h08, OP_OR  = 7'h0A, OP_XOR = 7'h0C;
    localparam logic [6:0] OP_BZ  = 7'h20, OP_LD  = 7'h21, OP_ADI = 7'h22, OP_SBI = 7'h25;
    localparam logic [6:0] OP_ANI = 7'h28, OP_ORI = 7'h2A, OP_XRI = 7'h2C, OP_NOT = 7'h2E;
    localparam logic [6:0] OP_LSL = 7'h30, OP_LSR = 7'h31, OP_MOV = 7'h40, OP_JMP = 7'h44;
    localparam logic [6:0] OP_SIU = 7'h45, OP_BNZ = 7'h60, OP_JMR = 7'h61, OP_AIU = 7'h62;
    localparam logic [6:0] OP_SLT = 7'h65;

    typedef struct packed {
        logic       rw, mw, ps, ma, mb, cs;
        logic [1:0] md, bs;
        logic [4:0] fs, da, aa, ba;
        logic       illegal;
    } ctrl_t;

    logic [6:0]       opcode;
    logic [4:0]       dr, sa, sb;
    logic [IMM_W-1:0] imm;
    assign opcode = bus.IR_instruction[31:25];
    assign dr     = bus.IR_instruction[24:20];
    assign sa     = bus.IR_instruction[19:15];
    assign sb     = bus.IR_instruction[14:10];
    assign imm    = bus.IR_instruction[IMM_W-1:0];

    ctrl_t             dec;
    logic              use_a, use_b;
    logic [DATA_W-1:0] imm_dec;

    always_comb begin
        dec    = '0;
        dec.da = dr;
        dec.aa = sa;
        dec.ba = sb;
        use_a  = 1'b1;
        use_b  = 1'b0;
        case (opcode)
            OP_ADD: begin dec.rw = 1'b1; dec.fs = 5'b00010; use_b = 1'b1; end
            OP_SUB: begin dec.rw = 1'b1; dec.fs = 5'b00101; use_b = 1'b1; end
            OP_AND: begin dec.rw = 1'b1; dec.fs = 5'b01000; use_b = 1'b1; end
            OP_OR:  begin dec.rw = 1'b1; dec.fs = 5'b01010; use_b = 1'b1; end
            OP_XOR: begin dec.rw = 1'b1; dec.fs = 5'b01100; use_b = 1'b1; end
            OP_SLT: begin dec.rw = 1'b1; dec.fs = 5'b00101; dec.md = 2'b10; use_b = 1'b1; end
            OP_ADI: begin dec.rw = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1; dec.fs = 5'b00010; end
            OP_SBI: begin dec.rw = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1; dec.fs = 5'b00101; end
            OP_ANI: begin dec.rw = 1'b1; dec.mb = 1'b1; dec.fs = 5'b01000; end
            OP_ORI: begin dec.rw = 1'b1; dec.mb = 1'b1; dec.fs = 5'b01010; end
            OP_XRI: begin dec.rw = 1'b1; dec.mb = 1'b1; dec.fs = 5'b01100; end
            OP_AIU: begin dec.rw = 1'b1; dec.mb = 1'b1; dec.fs = 5'b00010; end
            OP_SIU: begin dec.rw = 1'b1; dec.mb = 1'b1; dec.fs = 5'b00101; end
            OP_MOV: begin dec.rw = 1'b1; dec.fs = 5'b00000; end
            OP_NOT: begin dec.rw = 1'b1; dec.fs = 5'b01110; end
            OP_LSL: begin dec.rw = 1'b1; dec.fs = 5'b10000; end
            OP_LSR: begin dec.rw = 1'b1; dec.fs = 5'b10001; end
            OP_ST:  begin dec.mw = 1'b1; use_b = 1'b1; end
            OP_LD:  begin dec.rw = 1'b1; dec.md = 2'b01; end
            OP_JMR: begin dec.bs = 2'b10; end
            OP_BZ:  begin dec.bs = 2'b01; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_BNZ: begin dec.bs = 2'b01; dec.ps = 1'b1; dec.mb = 1'b1; dec.cs = 1'b1; end
            OP_JMP: begin dec.bs = 2'b11; dec.mb = 1'b1; dec.cs = 1'b1; use_a = 1'b0; end
            OP_JML: begin
                dec.bs = 2'b11; dec.rw = 1'b1; dec.fs = 5'b00111;
                dec.mb = 1'b1; dec.ma = 1'b1; dec.cs = 1'b1; use_a = 1'b0;
            end
            OP_NOP: begin dec.da = '0; dec.aa = '0; dec.ba = '0; use_a = 1'b0; end
            default: begin
                // Unknown opcodes travel as a NOP so control can trap on the flag.
                dec.da = '0; dec.aa = '0; dec.ba = '0; use_a = 1'b0; dec.illegal = 1'b1;
            end
        endcase
        imm_dec = dec.cs ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : {{(DATA_W-IMM_W){1'b0}}, imm};
    end

    logic [4:0]        hist_q [HAZ_DEPTH];
    logic [4:0]        hist_d [HAZ_DEPTH];
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              out_valid_q, out_valid_d;
    logic              hit_a, hit_b, hazard, load, accept;

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (hist_q[i] == sa) hit_a = 1'b1;
            if (hist_q[i] == sb) hit_b = 1'b1;
        end
    end

    assign hazard       = bus.in_valid && ((use_a && sa != 5'd0 && hit_a) || (use_b && sb != 5'd0 && hit_b));
    assign load         = !out_valid_q || bus.out_ready;
    assign bus.in_ready = load && !hazard && !bus.flush && !RESET;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        hist_d      = hist_q;
        ctrl_d      = ctrl_q;
        imm_d       = imm_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            for (int i = 0; i < HAZ_DEPTH; i++) hist_d[i] = '0;
            out_valid_d = 1'b0;
        end else if (load) begin
            // Every load cycle ages the scoreboard; bubbles push a 0 entry.
            for (int i = HAZ_DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
            hist_d[0]   = (accept && dec.rw && dr != 5'd0) ? dr : 5'd0;
            out_valid_d = accept;
            if (accept) begin
                ctrl_d = dec;
                imm_d  = imm_dec;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hist_q      <= '{default: '0};
            ctrl_q      <= '0;
            imm_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            ctrl_q      <= ctrl_d;
            imm_q       <= imm_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.RW        = ctrl_q.rw;
    assign bus.MW        = ctrl_q.mw;
    assign bus.PS        = ctrl_q.ps;
    assign bus.MA        = ctrl_q.ma;
    assign bus.MB        = ctrl_q.mb;
    assign bus.CS        = ctrl_q.cs;
    assign bus.MD        = ctrl_q.md;
    assign bus.BS        = ctrl_q.bs;
    assign bus.FS        = ctrl_q.fs;
    assign bus.DA        = ctrl_q.da;
    assign bus.AA        = ctrl_q.aa;
    assign bus.BA        = ctrl_q.ba;
    assign bus.illegal   = ctrl_q.illegal;
    assign bus.imm_ext   = imm_q;
endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Scoreboard bench for pipelined_instruction_decoder: directed scenarios then random traffic
// against a table-driven instruction model with a queue-based destination history.
module tb_pipelined_instruction_decoder;
    localparam int DATA_W = 32;
    localparam int HAZ_DEPTH = 2;
    localparam int W = 63;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_instruction_decoder_if #(.DATA_W(DATA_W)) bus ();

    pipelined_instruction_decoder #(.DATA_W(DATA_W), .IMM_W(15), .HAZ_DEPTH(HAZ_DEPTH)) dut (
        .CLK(clk), .RESET(rst), .bus(bus.slave)
    );

    logic [W-1:0] dut_word;
    assign dut_word = {bus.RW, bus.MW, bus.PS, bus.MA, bus.MB, bus.CS, bus.MD, bus.BS, bus.FS,
                       bus.DA, bus.AA, bus.BA, bus.illegal, bus.imm_ext};

    typedef struct {
        bit       legal, rw, mw, ps, ma, mb, cs, use_a, use_b;
        bit [1:0] md, bs;
        bit [4:0] fs;
    } ref_t;

    ref_t         tab [128];
    bit   [6:0]   legal_ops [$];
    logic [W-1:0] exp_q [$];
    int           m_hist [$];
    bit           m_ov, m_known, m_prev_rst, last_acc;
    int           checks, errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic def(input bit [6:0] op, input bit rw, mw, ps, ma, mb, cs,
                       input bit [1:0] md, bs, input bit [4:0] fs, input bit ua, ub);
        tab[op] = '{legal: 1'b1, rw: rw, mw: mw, ps: ps, ma: ma, mb: mb, cs: cs,
                    use_a: ua, use_b: ub, md: md, bs: bs, fs: fs};
        legal_ops.push_back(op);
    endtask

    function automatic logic [31:0] mk_ir(input bit [6:0] op, input bit [4:0] dr, sa, sb, input bit [9:0] lo);
        return {op, dr, sa, sb, lo};
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [31:0] ir);
        ref_t       t = tab[ir[31:25]];
        bit         zero = !t.legal || ir[31:25] == 7'h00;
        bit   [4:0] da = zero ? 5'd0 : ir[24:20];
        bit   [4:0] aa = zero ? 5'd0 : ir[19:15];
        bit   [4:0] ba = zero ? 5'd0 : ir[14:10];
        int         iv = int'(ir[14:0]);
        if (t.cs && iv >= 16384) iv = iv - 32768;
        return {t.rw, t.mw, t.ps, t.ma, t.mb, t.cs, t.md, t.bs, t.fs, da, aa, ba, !t.legal, 32'(iv)};
    endfunction

    function automatic bit hazard_of(input logic [31:0] ir);
        ref_t t = tab[ir[31:25]];
        int   sa = int'(ir[19:15]);
        int   sb = int'(ir[14:10]);
        bit   hit = 1'b0;
        foreach (m_hist[i]) begin
            if (t.use_a && sa != 0 && m_hist[i] == sa) hit = 1'b1;
            if (t.use_b && sb != 0 && m_hist[i] == sb) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic clear_hist();
        m_hist.delete();
        for (int i = 0; i < HAZ_DEPTH; i++) m_hist.push_back(0);
    endtask

    task automatic do_cycle(input bit iv, input logic [31:0] ir, input bit ordy, input bit fl, input bit rs);
        bit load, exp_rdy;
        @(negedge clk);
        rst = rs;
        bus.flush = fl;
        bus.in_valid = iv;
        bus.IR_instruction = ir;
        bus.out_ready = ordy;
        load = !m_ov || ordy;
        exp_rdy = load && !(iv && hazard_of(ir)) && !fl && !rs;
        #1;
        chk("in_ready", bus.in_ready, exp_rdy);
        if (m_known) chk("out_valid", bus.out_valid, m_ov);
        if (rs && m_prev_rst) chk("reset_word", dut_word, '0);
        last_acc = iv && exp_rdy;
        @(posedge clk);
        m_prev_rst = rs;
        if (rs || fl) begin
            m_ov = 1'b0;
            clear_hist();
            exp_q.delete();
            if (rs) m_known = 1'b1;
        end else if (load) begin
            m_hist.push_front((last_acc && tab[ir[31:25]].rw && ir[24:20] != 5'd0) ? int'(ir[24:20]) : 0);
            void'(m_hist.pop_back());
            m_ov = last_acc;
            if (last_acc) exp_q.push_back(exp_word(ir));
        end
    endtask

    task automatic send(input logic [31:0] ir, output int stalls);
        bit done = 1'b0;
        stalls = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            do_cycle(1'b1, ir, 1'b1, 1'b0, 1'b0);
            if (last_acc) done = 1'b1;
            else stalls++;
        end
        chk("send_accepted", done, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compare the presented word against the head expectation; retire it on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %h expected none", dut_word);
                end else begin
                    chk("sb_word", dut_word, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int          st;
        logic [31:0] ir;
        bit   [6:0]  op;
        def(7'h00, 0,0,0,0,0,0, 2'b00, 2'b00, 5'b00000, 0, 0);
        def(7'h02, 1,0,0,0,0,0, 2'b00, 2'b00, 5'b00010, 1, 1);
        def(7'h05, 1,0,0,0,0,0, 2'b00, 2'b00, 5'b00101, 1, 1);
        def(7'h08, 1,0,0,0,0,0, 2'b00, 2'b00, 5'b01000, 1, 1);
        def(7'h0A, 1,0,0,0,0,0, 2'b00, 2'b00, 5'b01010, 1, 1);
        def(7'h0C, 1,0,0,0,0,0, 2'b00, 2'b00, 5'b01100, 1, 1);
        def(7'h65, 1,0,0,0,0,0, 2'b10, 2'b00, 5'b00101, 1, 1);
        def(7'h22, 1,0,0,0,1,1, 2'b00, 2'b00, 5'b00010, 1, 0);
        def(7'h25, 1,0,0,0,1,1, 2'b00, 2'b00, 5'b00101, 1, 0);
        def(7'h28, 1,0,0,0,1,0, 2'b00, 2'b00, 5'b01000, 1, 0);
        def(7'h2A, 1,0,0,0,1,0, 2'b00, 2'b00, 5'b01010, 1, 0);
        def(7'h2C, 1,0,0,0,1,0, 2'b00, 2'b00, 5'b01100, 1, 0);
        def(7'h62, 1,0,0,0,1,0, 2'b00, 2'b00, 5'b00010, 1, 0);
        def(7'h45, 1,0,0,0,1,0, 2'b00, 2'b00, 5'b00101, 1, 0);
        def(7'h40, 1,0,0,0,0,0, 2'b00, 2'b00, 5'b00000, 1, 0);
        def(7'h2E, 1,0,0,0,0,0, 2'b00, 2'b00, 5'b01110, 1, 0);
        def(7'h30, 1,0,0,0,0,0, 2'b00, 2'b00, 5'b10000, 1, 0);
        def(7'h31, 1,0,0,0,0,0, 2'b00, 2'b00, 5'b10001, 1, 0);
        def(7'h01, 0,1,0,0,0,0, 2'b00, 2'b00, 5'b00000, 1, 1);
        def(7'h21, 1,0,0,0,0,0, 2'b01, 2'b00, 5'b00000, 1, 0);
        def(7'h61, 0,0,0,0,0,0, 2'b00, 2'b10, 5'b00000, 1, 0);
        def(7'h20, 0,0,0,0,1,1, 2'b00, 2'b01, 5'b00000, 1, 0);
        def(7'h60, 0,0,1,0,1,1, 2'b00, 2'b01, 5'b00000, 1, 0);
        def(7'h44, 0,0,0,0,1,1, 2'b00, 2'b11, 5'b00000, 0, 0);
        def(7'h07, 1,0,0,1,1,1, 2'b00, 2'b11, 5'b00111, 0, 0);
        clear_hist();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.IR_instruction = '0;
        bus.out_ready = 1'b0;

        // Reset, then the reference ADD R3 = R1 + R2.
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        send(32'h0430_8800, st);
        // Immediate extension at the sign boundary.
        send(mk_ir(7'h22, 5'd9, 5'd0, 5'h1F, 10'h3FF), st);
        send(mk_ir(7'h28, 5'd10, 5'd0, 5'h1F, 10'h3FF), st);
        // RAW hazard: SUB R4 = R3 - R1 right after ADD R3 waits HAZ_DEPTH cycles.
        send(mk_ir(7'h02, 5'd3, 5'd1, 5'd2, 10'h0), st);
        send(mk_ir(7'h05, 5'd4, 5'd3, 5'd1, 10'h0), st);
        chk("raw_stalls", st, HAZ_DEPTH);
        send(mk_ir(7'h02, 5'd0, 5'd1, 5'd2, 10'h0), st);
        send(mk_ir(7'h05, 5'd4, 5'd3, 5'd1, 10'h0), st);
        chk("r0_no_stall", st, 0);
        // Backpressure on a MOV stream.
        send(mk_ir(7'h40, 5'd5, 5'd0, 5'd0, 10'h1), st);
        for (int k = 0; k < 3; k++) do_cycle(1'b1, mk_ir(7'h40, 5'd6, 5'd0, 5'd0, 10'h2), 1'b0, 1'b0, 1'b0);
        send(mk_ir(7'h40, 5'd6, 5'd0, 5'd0, 10'h2), st);
        chk("bp_no_stall_after_release", st, 0);
        idle(1);
        // Flush while a JMP is held and a hazard on R7 is pending.
        send(mk_ir(7'h02, 5'd7, 5'd1, 5'd2, 10'h0), st);
        send(mk_ir(7'h44, 5'd0, 5'd0, 5'd0, 10'h55), st);
        do_cycle(1'b1, mk_ir(7'h05, 5'd1, 5'd7, 5'd0, 10'h0), 1'b0, 1'b1, 1'b0);
        send(mk_ir(7'h05, 5'd1, 5'd7, 5'd0, 10'h0), st);
        chk("flush_clears_hazard", st, 0);
        // Illegal opcode.
        send(mk_ir(7'h7F, 5'd5, 5'd1, 5'd2, 10'h0), st);
        idle(1);
        // Reset arriving mid-stall drops the held word.
        send(mk_ir(7'h40, 5'd8, 5'd0, 5'd0, 10'h3), st);
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127))
                                             : legal_ops[$urandom_range(0, legal_ops.size() - 1)];
            ir = mk_ir(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 10'($urandom));
            do_cycle($urandom_range(0, 99) < 80, ir, $urandom_range(0, 99) < 75,
                     $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
        end
        idle(4);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
